conv_sequencer: RTL and testbench

Control sequencer for the 1D convolution MAC datapath. On a start pulse it walks every valid output position of a DATA_LEN-sample input against a KER_LEN-tap kernel. For each position it issues synchronous-read addresses to the sample and kernel memories, drives clear/enable strobes into the multiply-accumulate unit, and writes each finished result under a ready/write handshake. It sits between the top-level control (start/done) and the memories, MAC and result buffer.

---
 rtl/conv_sequencer_if.sv | 29 ++
 rtl/conv_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// Handshake bundle between the convolution sequencer and its surroundings:
// top-level start/done control, memory read addressing, MAC strobes and the
// result write port. The sequencer takes the slave view; whatever drives
// start/out_ready takes the master view.
interface conv_sequencer_if #(
  parameter int AW = 8
);
  logic          start;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] x_addr;
  logic [AW-1:0] h_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          y_we;
  logic [AW-1:0] y_addr;

  modport master (
    output start, out_ready,
    input  busy, done, rd_en, x_addr, h_addr, mac_en, mac_clr, y_we, y_addr
  );

  modport slave (
    input  start, out_ready,
    output busy, done, rd_en, x_addr, h_addr, mac_en, mac_clr, y_we, y_addr
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequencer for the 1D valid-convolution MAC datapath. Each run walks every
// output position i, reads KER_LEN sample/kernel pairs, lets the last product
// settle into the MAC, then writes the accumulator under a ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; all strobes low
//   S_RUN   | one read per cycle, x_addr = i+k, h_addr = k
//   S_WAIT  | last product of position i travelling into the MAC
//   S_WRITE | accumulator valid; write y[i] when the sink is ready
//   S_DONE  | one-cycle done pulse, back to idle
//
// Every output except y_we comes straight from a flop. y_we is the only
// combinational output so that a write lands in the same cycle the sink
// signals ready.
module conv_sequencer #(
  parameter int DATA_LEN = 16,
  parameter int KER_LEN  = 4,
  parameter int AW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  conv_sequencer_if.slave  bus
);

  localparam int            OUT_LEN = DATA_LEN - KER_LEN + 1;
  localparam logic [AW-1:0] K_LAST  = AW'(KER_LEN - 1);
  localparam logic [AW-1:0] I_LAST  = AW'(OUT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_i;
  logic [AW-1:0] r_k;
  logic          r_busy;
  logic          r_done;
  logic          r_rd_en;
  logic [AW-1:0] r_x_addr;
  logic [AW-1:0] r_h_addr;
  logic [AW-1:0] r_y_addr;
  logic          r_mac_en;
  logic          r_mac_clr;
  logic          w_write_go;

  // A write completes only while parked in WRITE with the sink ready.
  assign w_write_go = (r_state == S_WRITE) && bus.out_ready;

  // State, counters and registered outputs; outputs are loaded with the
  // values belonging to the state being entered so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_x_addr  <= '0;
      r_h_addr  <= '0;
      r_y_addr  <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      // The memories answer one cycle after the read, so the MAC strobes
      // trail rd_en by one cycle; the first tap of a position clears.
      r_mac_en  <= r_rd_en;
      r_mac_clr <= r_rd_en && (r_k == '0);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_i      <= '0;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_rd_en  <= 1'b1;
            r_x_addr <= '0;
            r_h_addr <= '0;
          end
        end

        S_RUN: begin
          if (r_k == K_LAST) begin
            r_state  <= S_WAIT;
            r_k      <= '0;
            r_rd_en  <= 1'b0;
            r_x_addr <= '0;
            r_h_addr <= '0;
          end else begin
            r_k      <= r_k + 1'b1;
            r_x_addr <= r_i + r_k + 1'b1;
            r_h_addr <= r_k + 1'b1;
          end
        end

        S_WAIT: begin
          r_state  <= S_WRITE;
          r_y_addr <= r_i;
        end

        S_WRITE: begin
          // Without ready nothing moves; the MAC is idle so the
          // accumulator keeps its value until the sink takes it.
          if (bus.out_ready) begin
            r_y_addr <= '0;
            if (r_i == I_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_RUN;
              r_i      <= r_i + 1'b1;
              r_rd_en  <= 1'b1;
              r_x_addr <= r_i + 1'b1;
              r_h_addr <= '0;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.x_addr  = r_x_addr;
  assign bus.h_addr  = r_h_addr;
  assign bus.mac_en  = r_mac_en;
  assign bus.mac_clr = r_mac_clr;
  assign bus.y_we    = w_write_go;
  assign bus.y_addr  = r_y_addr;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer. Three instances cover the default geometry,
// DATA_LEN=KER_LEN=4 and KER_LEN=1. Expected per-cycle behaviour is laid out
// as a trace built from the run structure (reads, wait, stalls, write, done);
// the default instance also drives sample/kernel memories and a MAC model so
// written results can be compared with directly computed convolution sums.
module tb_conv_sequencer;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_sequencer_if #(.AW(AW)) bus0 ();
  conv_sequencer_if #(.AW(AW)) bus1 ();
  conv_sequencer_if #(.AW(AW)) bus2 ();

  conv_sequencer #(.DATA_LEN(16), .KER_LEN(4), .AW(AW)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  conv_sequencer #(.DATA_LEN(4),  .KER_LEN(4), .AW(AW)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  conv_sequencer #(.DATA_LEN(6),  .KER_LEN(1), .AW(AW)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic          start, rdy;
    logic          busy, done, rd_en, first, mac_en, mac_clr, y_we;
    logic [AW-1:0] x_addr, h_addr, y_addr;
  } cyc_t;

  cyc_t tr[$];
  int   total = 0;
  int   bad = 0;

  // memory + MAC environment around dut0
  int   xmem[0:255];
  int   hmem[0:255];
  int   res[0:255];
  int   x_q, h_q, acc, wr_cnt;
  logic mon_clr = 1'b0;

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0;
      for (int j = 0; j < 256; j++) res[j] <= -1;
    end else if (bus0.y_we) begin
      res[bus0.y_addr] <= acc;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus0.rd_en) begin
      x_q <= xmem[bus0.x_addr];
      h_q <= hmem[bus0.h_addr];
    end
    if (bus0.mac_en) acc <= bus0.mac_clr ? x_q * h_q : acc + x_q * h_q;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic busy_start(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  function automatic logic free_rdy(input int mode);
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic push_idle(input logic st);
    cyc_t c;
    c = '{default: 0};
    c.start = st;
    c.rdy = 1'($urandom_range(0, 1));
    tr.push_back(c);
  endtask

  // mode 0: quiet directed, 1: random start/ready noise and stalls, 2: start held
  task automatic add_run(input int kl, input int outn, input int stall_at, input int stall_n, input int mode);
    cyc_t c;
    int   ns;
    c = '{default: 0};
    c.start = 1'b1;
    c.rdy = free_rdy(mode);
    tr.push_back(c);
    for (int i = 0; i < outn; i++) begin
      for (int k = 0; k < kl; k++) begin
        c = '{default: 0};
        c.start = busy_start(mode); c.rdy = free_rdy(mode);
        c.busy = 1'b1; c.rd_en = 1'b1; c.first = (k == 0);
        c.x_addr = AW'(i + k); c.h_addr = AW'(k);
        tr.push_back(c);
      end
      c = '{default: 0};
      c.start = busy_start(mode); c.rdy = free_rdy(mode); c.busy = 1'b1;
      tr.push_back(c);
      ns = (mode == 1) ? int'($urandom_range(0, 2)) : ((i == stall_at) ? stall_n : 0);
      for (int s = 0; s < ns; s++) begin
        c = '{default: 0};
        c.start = busy_start(mode); c.rdy = 1'b0; c.busy = 1'b1;
        tr.push_back(c);
      end
      c = '{default: 0};
      c.start = busy_start(mode); c.rdy = 1'b1; c.busy = 1'b1;
      c.y_we = 1'b1; c.y_addr = AW'(i);
      tr.push_back(c);
    end
    c = '{default: 0};
    c.start = busy_start(mode); c.rdy = free_rdy(mode);
    c.busy = 1'b1; c.done = 1'b1;
    tr.push_back(c);
  endtask

  task automatic drive(input int sel, input logic st, input logic rdy);
    bus0.start = 1'b0; bus0.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.out_ready = 1'b0;
    bus2.start = 1'b0; bus2.out_ready = 1'b0;
    case (sel)
      0: begin bus0.start = st; bus0.out_ready = rdy; end
      1: begin bus1.start = st; bus1.out_ready = rdy; end
      default: begin bus2.start = st; bus2.out_ready = rdy; end
    endcase
  endtask

  task automatic sample(input int sel, output cyc_t o);
    o = '{default: 0};
    case (sel)
      0: begin
        o.busy = bus0.busy; o.done = bus0.done; o.rd_en = bus0.rd_en; o.mac_en = bus0.mac_en;
        o.mac_clr = bus0.mac_clr; o.y_we = bus0.y_we; o.x_addr = bus0.x_addr;
        o.h_addr = bus0.h_addr; o.y_addr = bus0.y_addr;
      end
      1: begin
        o.busy = bus1.busy; o.done = bus1.done; o.rd_en = bus1.rd_en; o.mac_en = bus1.mac_en;
        o.mac_clr = bus1.mac_clr; o.y_we = bus1.y_we; o.x_addr = bus1.x_addr;
        o.h_addr = bus1.h_addr; o.y_addr = bus1.y_addr;
      end
      default: begin
        o.busy = bus2.busy; o.done = bus2.done; o.rd_en = bus2.rd_en; o.mac_en = bus2.mac_en;
        o.mac_clr = bus2.mac_clr; o.y_we = bus2.y_we; o.x_addr = bus2.x_addr;
        o.h_addr = bus2.h_addr; o.y_addr = bus2.y_addr;
      end
    endcase
  endtask

  task automatic check_zero(input string name);
    cyc_t o;
    sample(0, o);
    check({name, " busy"}, o.busy, 0);
    check({name, " done"}, o.done, 0);
    check({name, " rd_en"}, o.rd_en, 0);
    check({name, " mac_en"}, o.mac_en, 0);
    check({name, " mac_clr"}, o.mac_clr, 0);
    check({name, " y_we"}, o.y_we, 0);
    check({name, " x_addr"}, o.x_addr, 0);
    check({name, " h_addr"}, o.h_addr, 0);
    check({name, " y_addr"}, o.y_addr, 0);
  endtask

  // Cycle c of the trace is the cycle whose inputs are tr[c]; trace index 0
  // is the start cycle in IDLE.
  task automatic run_trace(input int sel, input int ncyc, input string name);
    cyc_t o;
    int   n;
    for (int c = 0; c < tr.size(); c++) begin
      tr[c].mac_en  = (c > 0) ? tr[c-1].rd_en : 1'b0;
      tr[c].mac_clr = (c > 0) ? (tr[c-1].rd_en && tr[c-1].first) : 1'b0;
    end
    n = (ncyc < 0) ? tr.size() : ncyc;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      drive(sel, tr[c].start, tr[c].rdy);
      @(negedge clk);
      sample(sel, o);
      check($sformatf("%s c%0d busy", name, c), o.busy, tr[c].busy);
      check($sformatf("%s c%0d done", name, c), o.done, tr[c].done);
      check($sformatf("%s c%0d rd_en", name, c), o.rd_en, tr[c].rd_en);
      check($sformatf("%s c%0d mac_en", name, c), o.mac_en, tr[c].mac_en);
      check($sformatf("%s c%0d mac_clr", name, c), o.mac_clr, tr[c].mac_clr);
      check($sformatf("%s c%0d y_we", name, c), o.y_we, tr[c].y_we);
      if (tr[c].rd_en) begin
        check($sformatf("%s c%0d x_addr", name, c), o.x_addr, tr[c].x_addr);
        check($sformatf("%s c%0d h_addr", name, c), o.h_addr, tr[c].h_addr);
      end
      if (tr[c].y_we) check($sformatf("%s c%0d y_addr", name, c), o.y_addr, tr[c].y_addr);
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic check_results(input string name, input int nwr);
    int s;
    for (int i = 0; i < 13; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += xmem[i + k] * hmem[k];
      check($sformatf("%s y[%0d]", name, i), res[i], s);
    end
    check({name, " writes"}, wr_cnt, nwr);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0);
    for (int j = 0; j < 256; j++) begin xmem[j] = 0; hmem[j] = 0; end
    repeat (3) @(negedge clk);
    check_zero("reset");
    bus0.out_ready = 1'b1;
    #1 check({"reset", " y_we rdy"}, bus0.y_we, 0);
    bus0.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // golden data, ready always high
    for (int j = 0; j < 16; j++) xmem[j] = j + 1;
    for (int k = 0; k < 4; k++) hmem[k] = k + 1;
    check("gold ref y0", 1*1 + 2*2 + 3*3 + 4*4, 30);
    clear_mon();
    tr.delete(); add_run(4, 13, -1, 0, 0); push_idle(1'b0);
    run_trace(0, -1, "gold");
    check_results("gold", 13);
    check("gold y[12]", res[12], 150);

    // 3-cycle stall on output 5
    clear_mon();
    tr.delete(); add_run(4, 13, 5, 3, 0); push_idle(1'b0);
    run_trace(0, -1, "bp");
    check_results("bp", 13);

    // random data, random stalls and start noise
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 16; j++) xmem[j] = int'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) hmem[k] = int'($urandom_range(0, 255));
      clear_mon();
      tr.delete(); add_run(4, 13, -1, 0, 1); push_idle(1'b0);
      run_trace(0, -1, $sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), 13);
    end

    // asynchronous reset in cycle 20, then a fresh full run
    clear_mon();
    tr.delete(); add_run(4, 13, -1, 0, 0);
    run_trace(0, 21, "pre_rst");
    #2 reset = 1'b0;
    bus0.out_ready = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_hold");
    reset = 1'b1;
    bus0.out_ready = 1'b0;
    @(negedge clk);
    clear_mon();
    tr.delete(); add_run(4, 13, -1, 0, 0); push_idle(1'b0);
    run_trace(0, -1, "post_rst");
    check_results("post_rst", 13);

    // start held high: back-to-back runs with one idle cycle between
    clear_mon();
    tr.delete();
    for (int r = 0; r < 3; r++) add_run(4, 13, -1, 0, 2);
    push_idle(1'b0);
    run_trace(0, -1, "held");
    check_results("held", 39);

    // DATA_LEN = KER_LEN = 4: one write in cycle 6, done in cycle 7
    tr.delete(); add_run(4, 1, -1, 0, 0); push_idle(1'b0); push_idle(1'b0);
    run_trace(1, -1, "small");

    // KER_LEN = 1 with random noise
    tr.delete(); add_run(1, 6, -1, 0, 1); push_idle(1'b0);
    add_run(1, 6, 2, 2, 0); push_idle(1'b0);
    run_trace(2, -1, "k1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
